// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS R2000 decode stage: opcodes, functs, ALU ops, control bundle.
package mips_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // ADD/SUB trap on overflow in EX; the U variants never do (also used for address/compare math).
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
    logic branch;
    logic bne;
    logic jump;
  } id_ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: two async reads, one sync write, r0 hardwired to zero.
// WB_BYPASS_EN: a read matching the writeback address this cycle returns wb data (write-first).
module id_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data_c,
  output logic [DATA_W-1:0] rt_data_c,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rs_data_c = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_data_c = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef WB_BYPASS_EN
    if (we && wa != '0 && wa == rs_addr) rs_data_c = wd;
    if (we && wa != '0 && wa == rt_addr) rt_data_c = wd;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// MIPS R2000 decode stage: regfile read, control decode, immediate extension, load-use stall, ID/EX register.
// Optional WB_BYPASS_EN enables same-cycle writeback forwarding inside id_regfile.
module id_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_in,
  input  logic [31:0]           inst_in,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  hold_pc,
  output logic                  hold_if,
  output logic [31:0]           ex_pc,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [31:0]           ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [4:0]            ex_shamt,
  output logic [3:0]            ex_alu_op,
  output id_ctrl_t              ex_ctrl,
  output logic                  ex_illegal
);

  logic [5:0]            op;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [DATA_W-1:0]     rs_data_c;
  logic [DATA_W-1:0]     rt_data_c;

  id_ctrl_t              ctrl_c;
  alu_op_e               alu_c;
  logic [31:0]           imm_c;
  logic [REG_ADDR_W-1:0] rd_c;
  logic                  illegal_c;
  logic                  uses_rt_c;
  logic                  stall_c;

  assign op    = inst_in[31:26];
  assign funct = inst_in[5:0];
  assign rs    = REG_ADDR_W'(inst_in[25:21]);
  assign rt    = REG_ADDR_W'(inst_in[20:16]);

  id_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs),
    .rt_addr   (rt),
    .rs_data_c (rs_data_c),
    .rt_data_c (rt_data_c),
    .we        (wb_we),
    .wa        (wb_addr),
    .wd        (wb_data)
  );

  // Instruction decoder.
  always_comb begin
    ctrl_c    = '0;
    alu_c     = ALU_ADDU;
    imm_c     = sext16(inst_in[15:0]);
    rd_c      = REG_ADDR_W'(inst_in[15:11]);
    illegal_c = 1'b0;
    uses_rt_c = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        uses_rt_c        = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
        unique case (funct)
          F_ADD:  alu_c = ALU_ADD;
          F_ADDU: alu_c = ALU_ADDU;
          F_SUB:  alu_c = ALU_SUB;
          F_SUBU: alu_c = ALU_SUBU;
          F_AND:  alu_c = ALU_AND;
          F_OR:   alu_c = ALU_OR;
          F_XOR:  alu_c = ALU_XOR;
          F_NOR:  alu_c = ALU_NOR;
          F_SLT:  alu_c = ALU_SLT;
          F_SLTU: alu_c = ALU_SLTU;
          F_SLL:  alu_c = ALU_SLL;
          F_SRL:  alu_c = ALU_SRL;
          F_SRA:  alu_c = ALU_SRA;
          F_JR: begin
            ctrl_c.reg_write = 1'b0;
            ctrl_c.reg_dst   = 1'b0;
            ctrl_c.jump      = 1'b1;
          end
          default: illegal_c = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        unique case (op)
          OP_ADDI:  alu_c = ALU_ADD;
          OP_ADDIU: alu_c = ALU_ADDU;
          OP_SLTI:  alu_c = ALU_SLT;
          OP_SLTIU: alu_c = ALU_SLTU;
          OP_ANDI:  alu_c = ALU_AND;
          OP_ORI:   alu_c = ALU_OR;
          OP_XORI:  alu_c = ALU_XOR;
          default:  alu_c = ALU_LUI;
        endcase
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) imm_c = {16'h0, inst_in[15:0]};
        if (op == OP_LUI) imm_c = {inst_in[15:0], 16'h0};
      end
      OP_LW: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.alu_src    = 1'b1;
      end
      OP_SW: begin
        uses_rt_c        = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        uses_rt_c     = 1'b1;
        alu_c         = ALU_SUBU;
        ctrl_c.branch = 1'b1;
        ctrl_c.bne    = (op == OP_BNE);
      end
      OP_J, OP_JAL: begin
        imm_c       = {6'h0, inst_in[25:0]};
        ctrl_c.jump = 1'b1;
        if (op == OP_JAL) begin
          ctrl_c.reg_write = 1'b1;
          rd_c             = REG_ADDR_W'(31);
        end
      end
      default: illegal_c = 1'b1;
    endcase
    // All-zero word is the canonical nop: sll r0 with no side effects.
    if (illegal_c || inst_in == '0) ctrl_c = '0;
  end

  // Load-use hazard against the load currently in EX.
  always_comb begin
    stall_c = ex_ctrl.mem_read && (ex_rt != '0) &&
              ((ex_rt == rs) || ((ex_rt == rt) && uses_rt_c));
    hold_pc = stall_c && !flush;
    hold_if = stall_c && !flush;
  end

  // ID/EX pipeline register; flush or stall inserts an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || stall_c) begin
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_alu_op  <= '0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
    end else begin
      ex_pc      <= pc_in;
      ex_rs_data <= rs_data_c;
      ex_rt_data <= rt_data_c;
      ex_imm     <= imm_c;
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_rd      <= rd_c;
      ex_shamt   <= inst_in[10:6];
      ex_alu_op  <= 4'(alu_c);
      ex_ctrl    <= ctrl_c;
      ex_illegal <= illegal_c;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus hazard, flush, bypass and reset sequences.
module tb_id_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, inst_in;
  logic        flush, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        hold_pc, hold_if;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [3:0]  ex_alu_op;
  logic [8:0]  ex_ctrl;
  logic        ex_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .hold_pc(hold_pc), .hold_if(hold_if), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [8:0]  ctrl;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_byp;
    // ctrl bits: reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,branch,bne,jump
    vecs[0]  = '{32'h00225020, 9'h108, 4'(ALU_ADD),  32'h00005020, 5'd10, 1'b0}; // add r10,r1,r2
    vecs[1]  = '{32'h00851822, 9'h108, 4'(ALU_SUB),  32'h00001822, 5'd3,  1'b0}; // sub r3,r4,r5
    vecs[2]  = '{32'h00E8302A, 9'h108, 4'(ALU_SLT),  32'h0000302A, 5'd6,  1'b0}; // slt r6,r7,r8
    vecs[3]  = '{32'h000208C3, 9'h108, 4'(ALU_SRA),  32'h000008C3, 5'd1,  1'b0}; // sra r1,r2,3
    vecs[4]  = '{32'h03E00008, 9'h001, 4'(ALU_ADDU), 32'h00000008, 5'd0,  1'b0}; // jr r31
    vecs[5]  = '{32'h2109FFFF, 9'h110, 4'(ALU_ADD),  32'hFFFFFFFF, 5'd31, 1'b0}; // addi r9,r8,-1
    vecs[6]  = '{32'h30228001, 9'h110, 4'(ALU_AND),  32'h00008001, 5'd16, 1'b0}; // andi
    vecs[7]  = '{32'h34058000, 9'h110, 4'(ALU_OR),   32'h00008000, 5'd16, 1'b0}; // ori r5,r0,0x8000
    vecs[8]  = '{32'h3C058000, 9'h110, 4'(ALU_LUI),  32'h80000000, 5'd16, 1'b0}; // lui r5,0x8000
    vecs[9]  = '{32'h2C64FFFE, 9'h110, 4'(ALU_SLTU), 32'hFFFFFFFE, 5'd31, 1'b0}; // sltiu
    vecs[10] = '{32'hAFA80004, 9'h050, 4'(ALU_ADDU), 32'h00000004, 5'd0,  1'b0}; // sw
    vecs[11] = '{32'h1022FFFC, 9'h004, 4'(ALU_SUBU), 32'hFFFFFFFC, 5'd31, 1'b0}; // beq
    vecs[12] = '{32'h1422FFFC, 9'h006, 4'(ALU_SUBU), 32'hFFFFFFFC, 5'd31, 1'b0}; // bne
    vecs[13] = '{32'h8C080000, 9'h1B0, 4'(ALU_ADDU), 32'h00000000, 5'd0,  1'b0}; // lw r8,0(r0)
    vecs[14] = '{32'h08000100, 9'h001, 4'(ALU_ADDU), 32'h00000100, 5'd0,  1'b0}; // j
    vecs[15] = '{32'h0C000100, 9'h101, 4'(ALU_ADDU), 32'h00000100, 5'd31, 1'b0}; // jal
    vecs[16] = '{32'h00000000, 9'h000, 4'(ALU_SLL),  32'h00000000, 5'd0,  1'b0}; // nop
    vecs[17] = '{32'hFC000000, 9'h000, 4'(ALU_ADDU), 32'h00000000, 5'd0,  1'b1}; // bad opcode
    vecs[18] = '{32'h00000001, 9'h000, 4'(ALU_ADDU), 32'h00000001, 5'd0,  1'b1}; // bad funct

    rst = 1'b1; pc_in = '0; inst_in = '0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    chk("rst_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_pc", ex_pc, 32'h0);
    chk("rst_hold", 32'({hold_pc, hold_if}), 32'h0);
    rst = 1'b0;
    step();

    // Decode table.
    for (int i = 0; i < 19; i++) begin
      inst_in = vecs[i].inst;
      pc_in   = 32'h00400000 + 32'(i * 4);
      step();
      chk($sformatf("v%0d_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_alu", i), 32'(ex_alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_ill", i), 32'(ex_illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_pc", i), ex_pc, 32'h00400000 + 32'(i * 4));
    end
    chk("sra_shamt", 32'(vecs[3].inst[10:6]), 32'd3);

    // Writeback then read: addi r9,r8,-1.
    inst_in = '0; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
    step();
    wb_we = 1'b0; inst_in = 32'h2109FFFF;
    step();
    chk("addi_rs_data", ex_rs_data, 32'h1234);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_alu_src", 32'(ex_ctrl[4]), 32'h1);

    // Load-use stall: lw r8 then add r10,r8,r8.
    inst_in = 32'h8C080000;
    step();
    inst_in = 32'h01085020;
    #1;
    chk("lu_hold_pc", 32'(hold_pc), 32'h1);
    chk("lu_hold_if", 32'(hold_if), 32'h1);
    step();
    chk("lu_bubble", 32'(ex_ctrl), 32'h0);
    chk("lu_release", 32'(hold_pc), 32'h0);
    step();
    chk("lu_add_ctrl", 32'(ex_ctrl), 32'h108);
    chk("lu_add_rs", 32'(ex_rs), 32'd8);
    chk("lu_add_data", ex_rt_data, 32'h1234);

    // Flush during a stall cycle.
    inst_in = 32'h8C080000;
    step();
    inst_in = 32'h01085020; flush = 1'b1;
    #1;
    chk("fl_hold_pc", 32'(hold_pc), 32'h0);
    chk("fl_hold_if", 32'(hold_if), 32'h0);
    step();
    chk("fl_bubble", 32'(ex_ctrl), 32'h0);
    flush = 1'b0; inst_in = '0;
    step();
    chk("fl_next", 32'(ex_ctrl), 32'h0);

    // Same-cycle writeback read of r3.
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    step();
    wb_data = 32'hA5; inst_in = 32'h00600820;
    step();
`ifdef WB_BYPASS_EN
    exp_byp = 32'hA5;
`else
    exp_byp = 32'h11;
`endif
    chk("byp_same", ex_rs_data, exp_byp);
    wb_we = 1'b0;
    step();
    chk("byp_next", ex_rs_data, 32'hA5);

    // Writes to r0 are dropped.
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD; inst_in = '0;
    step();
    wb_we = 1'b0; inst_in = 32'h00000820;
    step();
    chk("r0_zero", ex_rs_data, 32'h0);

    // Asynchronous reset mid-run clears ID/EX and regfile.
    inst_in = 32'h00225020; pc_in = 32'h00400100;
    step();
    #2 rst = 1'b1;
    #1;
    chk("mrst_ctrl", 32'(ex_ctrl), 32'h0);
    chk("mrst_pc", ex_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      inst_in = {6'h0, 5'(r), 5'(r), 5'd1, 5'd0, 6'h20};
      step();
      chk($sformatf("mrst_r%0d", r), ex_rs_data | ex_rt_data, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
